// File: rtl/neuron_stdp_unit_if.sv
// Bundle of the signals between the STDP engine and its surroundings.
// It carries the spike/learning control inputs, the weight table read back
// from the synapse bank, and the LTP/LTD write ports that drive the bank.
//   master : the side driving spikes/weights and receiving write strobes
//   slave  : the STDP engine itself
interface neuron_stdp_unit_if;
    logic        ena;
    logic        learn_en;
    logic        tick;
    logic        pre_valid;
    logic [5:0]  addr;
    logic        post_spike;
    logic [31:0] wtab;
    logic        ltp_we;
    logic [3:0]  ltp_idx;
    logic [1:0]  ltp_wdata;
    logic        ltd_we;
    logic [3:0]  ltd_idx;
    logic [1:0]  ltd_wdata;
    logic        busy;

    modport master (
        output ena, learn_en, tick, pre_valid, addr, post_spike, wtab,
        input  ltp_we, ltp_idx, ltp_wdata, ltd_we, ltd_idx, ltd_wdata, busy
    );

    modport slave (
        input  ena, learn_en, tick, pre_valid, addr, post_spike, wtab,
        output ltp_we, ltp_idx, ltp_wdata, ltd_we, ltd_idx, ltd_wdata, busy
    );
endinterface

// File: rtl/neuron_stdp_unit.sv
// STDP engine for the 16 programmable synapses of one neuron.
// Keeps a saturating-decay trace per programmable pre-synaptic input plus one
// post-synaptic trace. A post spike launches a 16-cycle sweep that potentiates
// synapses with a live pre trace; a pre spike inside the post window depresses
// the addressed synapse immediately.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - slave modport: ena, learn_en, tick, pre_valid, addr, post_spike,
//           wtab in; ltp_we/idx/wdata, ltd_we/idx/wdata, busy out
module neuron_stdp_unit #(
    parameter int TRACE_W   = 3,
    parameter int TRACE_MAX = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    neuron_stdp_unit_if.slave    bus
);
    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    localparam logic [TRACE_W-1:0] TRACE_LOAD = TRACE_W'(TRACE_MAX);
    localparam logic [TRACE_W-1:0] TRACE_ONE  = TRACE_W'(1);

    state_t             state_reg, state_next;
    logic [3:0]         sweep_idx_reg, sweep_idx_next;
    logic [TRACE_W-1:0] pre_trace_reg [16];
    logic [TRACE_W-1:0] post_trace_reg;
    logic [1:0]         w_entry [16];

    logic        ltp_we_reg, ltd_we_reg;
    logic [3:0]  ltp_idx_reg, ltd_idx_reg;
    logic [1:0]  ltp_wdata_reg, ltd_wdata_reg;

    logic        pre_load;
    logic [3:0]  pre_idx;
    logic [1:0]  w_pre, w_sweep;
    logic        ltd_fire, ltp_fire;

    // Unpack the weight table into one 2-bit entry per synapse.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_wtab
            assign w_entry[gi] = bus.wtab[2*gi +: 2];
        end
    endgenerate

    assign pre_load = bus.pre_valid && (bus.addr[5:4] == 2'b00);
    assign pre_idx  = bus.addr[3:0];
    assign w_pre    = w_entry[pre_idx];
    assign w_sweep  = w_entry[sweep_idx_reg];

    // Depression uses the post trace as it stood before this cycle's update.
    assign ltd_fire = pre_load && bus.learn_en && (post_trace_reg != '0) && (w_pre != 2'd0);

    // When depression hits the entry the sweep is looking at, depression wins.
    assign ltp_fire = (state_reg == SWEEP) && (pre_trace_reg[sweep_idx_reg] != '0)
                   && (w_sweep != 2'd3) && bus.learn_en
                   && !(ltd_fire && (pre_idx == sweep_idx_reg));

    // Pre traces: a spike reload beats a decay tick on the same entry.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pre_trace
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pre_trace_reg[gi] <= '0;
                end else if (bus.ena) begin
                    if (pre_load && (pre_idx == 4'(gi))) begin
                        pre_trace_reg[gi] <= TRACE_LOAD;
                    end else if (bus.tick && (pre_trace_reg[gi] != '0)) begin
                        pre_trace_reg[gi] <= pre_trace_reg[gi] - TRACE_ONE;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_trace_reg <= '0;
        end else if (bus.ena) begin
            if (bus.post_spike) begin
                post_trace_reg <= TRACE_LOAD;
            end else if (bus.tick && (post_trace_reg != '0)) begin
                post_trace_reg <= post_trace_reg - TRACE_ONE;
            end
        end
    end

    // Sweep FSM. A post spike during SWEEP only reloads the post trace.
    always_comb begin
        state_next     = state_reg;
        sweep_idx_next = sweep_idx_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.post_spike && bus.learn_en) begin
                    state_next     = SWEEP;
                    sweep_idx_next = 4'd0;
                end
            end
            SWEEP: begin
                sweep_idx_next = sweep_idx_reg + 4'd1;
                if (sweep_idx_reg == 4'd15) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                sweep_idx_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            sweep_idx_reg <= 4'd0;
        end else if (bus.ena) begin
            state_reg     <= state_next;
            sweep_idx_reg <= sweep_idx_next;
        end
    end

    // Strobes drop while disabled so nothing is replayed when ena returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ltp_we_reg    <= 1'b0;
            ltp_idx_reg   <= 4'd0;
            ltp_wdata_reg <= 2'd0;
            ltd_we_reg    <= 1'b0;
            ltd_idx_reg   <= 4'd0;
            ltd_wdata_reg <= 2'd0;
        end else if (!bus.ena) begin
            ltp_we_reg <= 1'b0;
            ltd_we_reg <= 1'b0;
        end else begin
            ltp_we_reg <= ltp_fire;
            ltd_we_reg <= ltd_fire;
            if (ltp_fire) begin
                ltp_idx_reg   <= sweep_idx_reg;
                ltp_wdata_reg <= w_sweep + 2'd1;
            end
            if (ltd_fire) begin
                ltd_idx_reg   <= pre_idx;
                ltd_wdata_reg <= w_pre - 2'd1;
            end
        end
    end

    assign bus.ltp_we    = ltp_we_reg;
    assign bus.ltp_idx   = ltp_idx_reg;
    assign bus.ltp_wdata = ltp_wdata_reg;
    assign bus.ltd_we    = ltd_we_reg;
    assign bus.ltd_idx   = ltd_idx_reg;
    assign bus.ltd_wdata = ltd_wdata_reg;
    assign bus.busy      = (state_reg == SWEEP);
endmodule

// File: tb/tb_neuron_stdp_unit.sv
module tb_neuron_stdp_unit;
    localparam int TMAX = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    neuron_stdp_unit_if bus();

    neuron_stdp_unit #(.TRACE_W(3), .TRACE_MAX(TMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Synapse bank stand-in: weights written by the model's expected strobes.
    logic [1:0] bank_w [16];
    always_comb begin
        bus.wtab = '0;
        for (int i = 0; i < 16; i++) bus.wtab[2*i +: 2] = bank_w[i];
    end

    int checks = 0;
    int errors = 0;
    int t = 0;

    // Behavioural reference state
    int m_pre [16];
    int m_post;
    bit m_active;
    int m_pos;
    bit e_ltp, e_ltd, e_busy;
    int e_ltp_idx, e_ltp_data, e_ltd_idx, e_ltd_data;

    function automatic logic [14:0] obs_vec();
        return {bus.ltp_we, bus.ltp_we ? bus.ltp_idx : 4'd0, bus.ltp_we ? bus.ltp_wdata : 2'd0,
                bus.ltd_we, bus.ltd_we ? bus.ltd_idx : 4'd0, bus.ltd_we ? bus.ltd_wdata : 2'd0,
                bus.busy};
    endfunction

    function automatic logic [14:0] exp_vec();
        return {e_ltp, e_ltp ? 4'(e_ltp_idx) : 4'd0, e_ltp ? 2'(e_ltp_data) : 2'd0,
                e_ltd, e_ltd ? 4'(e_ltd_idx) : 4'd0, e_ltd ? 2'(e_ltd_data) : 2'd0,
                e_busy};
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 16; j++) m_pre[j] = 0;
        m_post = 0; m_active = 0; m_pos = 0;
        e_ltp = 0; e_ltd = 0; e_busy = 0;
    endtask

    task automatic idle_inputs();
        bus.ena = 1'b1; bus.learn_en = 1'b1; bus.tick = 1'b0;
        bus.pre_valid = 1'b0; bus.addr = 6'h00; bus.post_spike = 1'b0;
    endtask

    // Advance one clock: predict outputs from the rules, then clock the DUT.
    task automatic cycle();
        bit prog, ltd, ltp;
        int i, k;
        prog = bus.pre_valid && (bus.addr[5:4] == 2'b00);
        i = int'(bus.addr[3:0]);
        k = m_pos;
        ltd = 0; ltp = 0;
        if (bus.ena) begin
            ltd = prog && bus.learn_en && (m_post > 0) && (bank_w[i] != 2'd0);
            ltp = m_active && (m_pre[k] > 0) && (bank_w[k] != 2'd3) && bus.learn_en && !(ltd && i == k);
            if (ltd) begin e_ltd_idx = i; e_ltd_data = int'(bank_w[i]) - 1; end
            if (ltp) begin e_ltp_idx = k; e_ltp_data = int'(bank_w[k]) + 1; end
            for (int j = 0; j < 16; j++) begin
                if (prog && i == j) m_pre[j] = TMAX;
                else if (bus.tick && m_pre[j] > 0) m_pre[j]--;
            end
            if (bus.post_spike) m_post = TMAX;
            else if (bus.tick && m_post > 0) m_post--;
            if (m_active) begin
                m_pos++;
                if (m_pos == 16) begin m_active = 0; m_pos = 0; end
            end else if (bus.post_spike && bus.learn_en) begin
                m_active = 1; m_pos = 0;
            end
        end
        e_ltp = ltp; e_ltd = ltd; e_busy = m_active;
        @(posedge clk); #1;
        t++;
        if (e_ltp) bank_w[e_ltp_idx] = 2'(e_ltp_data);
        if (e_ltd) bank_w[e_ltd_idx] = 2'(e_ltd_data);
        if (bus.ltp_we === 1'b1) $display("t=%0d LTP idx=%0d w=%0d", t, bus.ltp_idx, bus.ltp_wdata);
        if (bus.ltd_we === 1'b1) $display("t=%0d LTD idx=%0d w=%0d", t, bus.ltd_idx, bus.ltd_wdata);
    endtask

    // Let any sweep finish and decay every trace to zero.
    task automatic drain();
        for (int c = 0; c < 20; c++) begin
            idle_inputs(); bus.tick = 1'b1;
            cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        int n_busy, n_ltp;
        idle_inputs();
        for (int i = 0; i < 16; i++) bank_w[i] = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.ltp_we, bus.ltp_idx, bus.ltp_wdata, bus.ltd_we, bus.ltd_idx, bus.ltd_wdata, bus.busy} !== 15'd0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", {bus.ltp_we, bus.ltp_idx, bus.ltp_wdata, bus.ltd_we, bus.ltd_idx, bus.ltd_wdata, bus.busy});
        end
        rst_n = 1'b1;
        bank_w[1] = 2'd1;
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            if (c == 0) begin bus.pre_valid = 1'b1; bus.addr = 6'h01; end
            if (c == 1) bus.post_spike = 1'b1;
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL reset_presweep t=%0d got %h want %h", t, obs_vec(), exp_vec()); end
        end
        // Asynchronous reset in the middle of the sweep.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.ltp_we, bus.ltd_we, bus.busy} !== 3'b000) begin
            errors++; $display("FAIL reset_midsweep got we/we/busy=%b want 000", {bus.ltp_we, bus.ltd_we, bus.busy});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_busy = 0; n_ltp = 0;
        for (int c = 0; c < 20; c++) begin
            idle_inputs();
            if (c == 0) bus.post_spike = 1'b1;
            cycle();
            if (bus.busy === 1'b1) n_busy++;
            if (bus.ltp_we === 1'b1) n_ltp++;
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL reset_postsweep t=%0d got %h want %h", t, obs_vec(), exp_vec()); end
        end
        checks++;
        if (n_busy != 16 || n_ltp != 0) begin
            errors++; $display("FAIL reset_clean_sweep busy=%0d ltp=%0d want busy=16 ltp=0", n_busy, n_ltp);
        end
    endtask

    task automatic test_pre_post();
        int start, rel, n_ltp;
        drain();
        bank_w[5] = 2'd1;
        start = t; n_ltp = 0;
        for (int c = 0; c < 22; c++) begin
            idle_inputs();
            if (c == 0) begin bus.pre_valid = 1'b1; bus.addr = 6'h05; end
            if (c == 2) bus.post_spike = 1'b1;
            cycle();
            rel = t - start;
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL pre_post_model cycle=%0d got %h want %h", rel, obs_vec(), exp_vec()); end
            if (bus.ltp_we === 1'b1) begin
                n_ltp++;
                checks++;
                if (rel != 9 || bus.ltp_idx !== 4'd5 || bus.ltp_wdata !== 2'd2) begin
                    errors++; $display("FAIL pre_post_strobe cycle=%0d idx=%0d w=%0d want cycle=9 idx=5 w=2", rel, bus.ltp_idx, bus.ltp_wdata);
                end
            end
        end
        checks++;
        if (n_ltp != 1) begin errors++; $display("FAIL pre_post_count got %0d want 1", n_ltp); end
    endtask

    task automatic test_saturation();
        int n_ltp, n_ltd;
        drain();
        bank_w[3] = 2'd3; bank_w[7] = 2'd1;
        n_ltp = 0; n_ltd = 0;
        for (int c = 0; c < 22; c++) begin
            idle_inputs();
            if (c == 0) begin bus.pre_valid = 1'b1; bus.addr = 6'h03; end
            if (c == 1) bus.post_spike = 1'b1;
            if (c == 2) begin bus.pre_valid = 1'b1; bus.addr = 6'h13; end
            if (c == 3) begin bus.pre_valid = 1'b1; bus.addr = 6'h27; end
            cycle();
            if (bus.ltp_we === 1'b1) n_ltp++;
            if (bus.ltd_we === 1'b1) n_ltd++;
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL saturation_model t=%0d got %h want %h", t, obs_vec(), exp_vec()); end
        end
        checks++;
        if (n_ltp != 0 || n_ltd != 0) begin
            errors++; $display("FAIL saturation_nonprog ltp=%0d ltd=%0d want 0 0", n_ltp, n_ltd);
        end
    endtask

    task automatic test_depression();
        int start, rel, n_ltd;
        for (int pass = 0; pass < 2; pass++) begin
            drain();
            bank_w[2] = (pass == 0) ? 2'd2 : 2'd0;
            start = t; n_ltd = 0;
            for (int c = 0; c < 20; c++) begin
                idle_inputs();
                if (c == 0) bus.post_spike = 1'b1;
                if (c == 3) begin bus.pre_valid = 1'b1; bus.addr = 6'h02; end
                cycle();
                rel = t - start;
                checks++;
                if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL depress_model cycle=%0d got %h want %h", rel, obs_vec(), exp_vec()); end
                if (bus.ltd_we === 1'b1) begin
                    n_ltd++;
                    checks++;
                    if (rel != 4 || bus.ltd_idx !== 4'd2 || bus.ltd_wdata !== 2'd1) begin
                        errors++; $display("FAIL depress_strobe cycle=%0d idx=%0d w=%0d want cycle=4 idx=2 w=1", rel, bus.ltd_idx, bus.ltd_wdata);
                    end
                end
            end
            checks++;
            if (n_ltd != ((pass == 0) ? 1 : 0)) begin
                errors++; $display("FAIL depress_count pass=%0d got %0d want %0d", pass, n_ltd, (pass == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_decay();
        int n_idx0;
        for (int n = 7; n >= 6; n--) begin
            drain();
            bank_w[0] = 2'd1;
            n_idx0 = 0;
            for (int c = 0; c < n + 21; c++) begin
                idle_inputs();
                if (c == 0) begin bus.pre_valid = 1'b1; bus.addr = 6'h00; end
                if (c >= 1 && c <= n) bus.tick = 1'b1;
                if (c == n + 1) bus.post_spike = 1'b1;
                cycle();
                if (bus.ltp_we === 1'b1 && bus.ltp_idx === 4'd0) n_idx0++;
                checks++;
                if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL decay_model t=%0d got %h want %h", t, obs_vec(), exp_vec()); end
            end
            checks++;
            if (n_idx0 != ((n == 7) ? 0 : 1)) begin
                errors++; $display("FAIL decay_ticks=%0d idx0 strobes got %0d want %0d", n, n_idx0, (n == 7) ? 0 : 1);
            end
        end
    endtask

    task automatic test_collision_ena();
        int start, rel;
        drain();
        bank_w[4] = 2'd1; bank_w[9] = 2'd1; bank_w[10] = 2'd1;
        start = t;
        for (int c = 0; c < 30; c++) begin
            idle_inputs();
            if (c == 0) begin bus.pre_valid = 1'b1; bus.addr = 6'h09; end
            if (c == 1) begin bus.pre_valid = 1'b1; bus.addr = 6'h0a; end
            if (c == 2) begin bus.pre_valid = 1'b1; bus.addr = 6'h04; end
            if (c == 3) bus.post_spike = 1'b1;
            if (c == 8) begin bus.pre_valid = 1'b1; bus.addr = 6'h04; end
            if (c >= 14 && c <= 18) bus.ena = 1'b0;
            cycle();
            rel = t - start;
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL coll_model cycle=%0d got %h want %h", rel, obs_vec(), exp_vec()); end
            if (rel == 9) begin
                checks++;
                if (bus.ltd_we !== 1'b1 || bus.ltd_idx !== 4'd4 || bus.ltd_wdata !== 2'd0 || bus.ltp_we !== 1'b0) begin
                    errors++; $display("FAIL collision ltd=%b idx=%0d w=%0d ltp=%b want ltd=1 idx=4 w=0 ltp=0", bus.ltd_we, bus.ltd_idx, bus.ltd_wdata, bus.ltp_we);
                end
            end
            if (rel == 14 || rel == 20) begin
                checks++;
                if (bus.ltp_we !== 1'b1 || bus.ltp_idx !== ((rel == 14) ? 4'd9 : 4'd10) || bus.ltp_wdata !== 2'd2) begin
                    errors++; $display("FAIL ena_resume cycle=%0d ltp=%b idx=%0d w=%0d want ltp=1 idx=%0d w=2", rel, bus.ltp_we, bus.ltp_idx, bus.ltp_wdata, (rel == 14) ? 9 : 10);
                end
            end
            if (rel >= 15 && rel <= 19) begin
                checks++;
                if (bus.ltp_we !== 1'b0 || bus.ltd_we !== 1'b0 || bus.busy !== 1'b1) begin
                    errors++; $display("FAIL ena_hold cycle=%0d ltp=%b ltd=%b busy=%b want 0 0 1", rel, bus.ltp_we, bus.ltd_we, bus.busy);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            idle_inputs();
            bus.ena        = ($urandom_range(0, 7) != 0);
            bus.learn_en   = ($urandom_range(0, 5) != 0);
            bus.tick       = ($urandom_range(0, 3) == 0);
            bus.pre_valid  = ($urandom_range(0, 2) == 0);
            bus.addr       = {($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, 4'($urandom)};
            bus.post_spike = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) bank_w[$urandom_range(0, 15)] = 2'($urandom);
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL random_model t=%0d got %h want %h", t, obs_vec(), exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_pre_post();
        test_saturation();
        test_depression();
        test_decay();
        test_collision_ena();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
